// File: rtl/ntree_lookup_pipe.sv
// FANOUT-ary pipelined search tree: one registered stage per level, double-banked
// pivot tables with atomic swap, and a credit-guarded in-order result FIFO.
module ntree_lookup_pipe #(
  parameter int LEVEL_CNT      = 3,
  parameter int FANOUT         = 4,
  parameter int KEY_WIDTH      = 16,
  parameter int BYPASS_WIDTH   = 1,
  parameter int OUT_FIFO_DEPTH = 4,
  localparam int FW            = $clog2(FANOUT),
  localparam int ADDR_WIDTH    = LEVEL_CNT * FW,
  localparam int NODE_W        = (LEVEL_CNT > 1) ? (LEVEL_CNT - 1) * FW : 1,
  localparam int LVL_W         = (LEVEL_CNT > 1) ? $clog2(LEVEL_CNT) : 1,
  localparam int MM_DATA_WIDTH = (FANOUT - 1) * KEY_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [LVL_W+NODE_W-1:0]  mm_addr_i,
  input  logic [MM_DATA_WIDTH-1:0] mm_wdata_i,
  input  logic                     mm_wr_i,
  input  logic                     mm_rd_i,
  output logic [MM_DATA_WIDTH-1:0] mm_rdata_o,
  output logic                     mm_rdvalid_o,
  input  logic                     swap_i,
  output logic                     mm_busy_o,
  output logic                     active_bank_o,
  input  logic [KEY_WIDTH-1:0]     lookup_key_i,
  input  logic [BYPASS_WIDTH-1:0]  lookup_bypass_i,
  input  logic                     lookup_valid_i,
  output logic                     lookup_ready_o,
  output logic                     lookup_valid_o,
  input  logic                     lookup_ready_i,
  output logic [ADDR_WIDTH-1:0]    lookup_addr_o,
  output logic                     lookup_match_o,
  output logic [BYPASS_WIDTH-1:0]  lookup_bypass_o
);
  localparam int NODES  = 2 ** NODE_W;
  localparam int CNT_W  = $clog2(OUT_FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(OUT_FIFO_DEPTH);
  localparam int BUSY_W = $clog2(LEVEL_CNT + 1);

  typedef struct packed {
    logic [KEY_WIDTH-1:0]    key;
    logic [BYPASS_WIDTH-1:0] byp;
    logic                    bank;
    logic [NODE_W-1:0]       node;
    logic [ADDR_WIDTH-1:0]   addr;
  } stage_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    match;
    logic [BYPASS_WIDTH-1:0] byp;
  } result_t;

  logic [MM_DATA_WIDTH-1:0] piv_q [2][LEVEL_CNT][NODES];
  logic                     bank_q;
  logic [BUSY_W-1:0]        busy_q;
  logic [MM_DATA_WIDTH-1:0] rdata_q;
  logic                     rdvalid_q;

  logic [LVL_W-1:0]  mm_lvl;
  logic [NODE_W-1:0] mm_node;
  logic              mm_ok;

  assign {mm_lvl, mm_node} = mm_addr_i;

  // Only levels that exist and nodes that exist at that level are addressable.
  always_comb begin
    mm_ok = 1'b0;
    for (int l = 0; l < LEVEL_CNT; l++)
      if (int'(mm_lvl) == l && int'(mm_node) < (1 << (l * FW))) mm_ok = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int bk = 0; bk < 2; bk++)
        for (int l = 0; l < LEVEL_CNT; l++)
          for (int n = 0; n < NODES; n++) piv_q[bk][l][n] <= '0;
      bank_q    <= 1'b0;
      busy_q    <= '0;
      rdata_q   <= '0;
      rdvalid_q <= 1'b0;
    end else begin
      rdvalid_q <= mm_rd_i;
      if (mm_rd_i) rdata_q <= mm_ok ? piv_q[~bank_q][mm_lvl][mm_node] : '0;
      if (mm_wr_i && busy_q == '0 && mm_ok) piv_q[~bank_q][mm_lvl][mm_node] <= mm_wdata_i;
      // Busy covers the drain of lookups still walking the retired bank.
      if (busy_q != '0) busy_q <= busy_q - BUSY_W'(1);
      else if (swap_i) begin
        bank_q <= ~bank_q;
        busy_q <= BUSY_W'(LEVEL_CNT);
      end
    end
  end

  assign mm_rdata_o    = rdata_q;
  assign mm_rdvalid_o  = rdvalid_q;
  assign mm_busy_o     = (busy_q != '0);
  assign active_bank_o = bank_q;

  stage_t                   st_q [LEVEL_CNT];
  stage_t                   st_d [LEVEL_CNT];
  logic [LEVEL_CNT-1:0]     vld_pipe_q;
  logic [MM_DATA_WIDTH-1:0] piv_c;
  logic [FW-1:0]            b_c;
  logic [FW-1:0]            bm1_c;
  logic                     last_match;
  logic                     accept;

  always_comb begin
    piv_c      = '0;
    b_c        = '0;
    bm1_c      = '0;
    last_match = 1'b0;
    for (int l = 0; l < LEVEL_CNT; l++) begin
      st_d[l] = st_q[l];
      piv_c   = piv_q[st_q[l].bank][l][st_q[l].node];
      b_c     = '0;
      for (int k = 0; k < FANOUT - 1; k++)
        if (st_q[l].key >= piv_c[k*KEY_WIDTH +: KEY_WIDTH]) b_c = b_c + FW'(1);
      st_d[l].node = NODE_W'({st_q[l].node, b_c});
      st_d[l].addr = ADDR_WIDTH'({st_q[l].addr, b_c});
      bm1_c = b_c - FW'(1);
      if (l == LEVEL_CNT - 1)
        last_match = (b_c != '0) && (st_q[l].key == piv_c[bm1_c*KEY_WIDTH +: KEY_WIDTH]);
    end
  end

  assign accept = lookup_valid_i && lookup_ready_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) vld_pipe_q <= '0;
    else          vld_pipe_q <= LEVEL_CNT'({vld_pipe_q, accept});
  end

  always_ff @(posedge clk_i) begin
    st_q[0].key  <= lookup_key_i;
    st_q[0].byp  <= lookup_bypass_i;
    st_q[0].bank <= bank_q;
    st_q[0].node <= '0;
    st_q[0].addr <= '0;
    for (int l = 1; l < LEVEL_CNT; l++) st_q[l] <= st_d[l-1];
  end

  result_t          fifo_q [OUT_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push, pop;
  result_t          res;

  assign push = vld_pipe_q[LEVEL_CNT-1];
  assign pop  = lookup_valid_o && lookup_ready_i;
  assign res  = '{addr: st_d[LEVEL_CNT-1].addr, match: last_match, byp: st_q[LEVEL_CNT-1].byp};

  // Credits count in-flight lookups so the non-stalling pipe can never overfill the FIFO.
  assign lookup_ready_o = (int'(cnt_q) + $countones(vld_pipe_q)) < OUT_FIFO_DEPTH;

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= res;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(OUT_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(OUT_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign lookup_valid_o  = (cnt_q != '0);
  assign lookup_addr_o   = fifo_q[rd_ptr_q].addr;
  assign lookup_match_o  = fifo_q[rd_ptr_q].match;
  assign lookup_bypass_o = fifo_q[rd_ptr_q].byp;

endmodule

// File: tb/tb_ntree_lookup_pipe.sv
// Directed bench for ntree_lookup_pipe at default parameters (FANOUT=4, LEVEL_CNT=3).
module tb_ntree_lookup_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  mm_addr = '0;
  logic [47:0] mm_wdata = '0, mm_rdata;
  logic        mm_wr = 1'b0, mm_rd = 1'b0, mm_rdvalid, swap = 1'b0, busy, abank;
  logic [15:0] key = '0;
  logic        byp_i = 1'b0, lv_i = 1'b0, lr_o, lv_o, lr_i = 1'b1, lmatch, byp_o;
  logic [5:0]  laddr;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  ntree_lookup_pipe dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .mm_addr_i(mm_addr), .mm_wdata_i(mm_wdata), .mm_wr_i(mm_wr), .mm_rd_i(mm_rd),
    .mm_rdata_o(mm_rdata), .mm_rdvalid_o(mm_rdvalid),
    .swap_i(swap), .mm_busy_o(busy), .active_bank_o(abank),
    .lookup_key_i(key), .lookup_bypass_i(byp_i), .lookup_valid_i(lv_i), .lookup_ready_o(lr_o),
    .lookup_valid_o(lv_o), .lookup_ready_i(lr_i), .lookup_addr_o(laddr),
    .lookup_match_o(lmatch), .lookup_bypass_o(byp_o)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mm_write(input int lvl, input int node, input logic [47:0] d);
    mm_addr = {2'(lvl), 4'(node)}; mm_wdata = d; mm_wr = 1'b1;
    tick();
    mm_wr = 1'b0;
  endtask

  task automatic mm_read(input int lvl, input int node, output logic [47:0] d, output logic v);
    mm_addr = {2'(lvl), 4'(node)}; mm_rd = 1'b1;
    tick();
    mm_rd = 1'b0;
    d = mm_rdata; v = mm_rdvalid;
  endtask

  // Single lookup with ready_i high; lat counts cycles from accept to valid output.
  task automatic lookup1(input logic [15:0] k, input logic b, output logic [5:0] a,
                         output logic m, output logic bo, output int lat);
    key = k; byp_i = b; lv_i = 1'b1;
    tick();
    lv_i = 1'b0; lat = 1;
    while (!lv_o && lat < 20) begin tick(); lat++; end
    a = laddr; m = lmatch; bo = byp_o;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_chk++; if (lv_o !== 1'b0)       begin n_fail++; $display("FAIL reset_valid: got %b want 0", lv_o); end
    n_chk++; if (mm_rdvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rdvalid: got %b want 0", mm_rdvalid); end
    n_chk++; if (mm_rdata !== 48'h0)  begin n_fail++; $display("FAIL reset_rdata: got %h want 0", mm_rdata); end
    n_chk++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (abank !== 1'b0)      begin n_fail++; $display("FAIL reset_bank: got %b want 0", abank); end
    n_chk++; if (lr_o !== 1'b1)       begin n_fail++; $display("FAIL reset_ready: got %b want 1", lr_o); end
  endtask

  task automatic test_default_lookup();
    logic [5:0] a; logic m, bo; int lat;
    lookup1(16'h1234, 1'b0, a, m, bo, lat);
    n_chk++; if (a !== 6'd63 || m !== 1'b0) begin n_fail++; $display("FAIL zero_tbl_1234: got addr %0d match %b want 63 0", a, m); end
    n_chk++; if (lat != 4) begin n_fail++; $display("FAIL latency_1: got %0d want 4", lat); end
    lookup1(16'h0000, 1'b1, a, m, bo, lat);
    n_chk++; if (a !== 6'd63 || m !== 1'b1 || bo !== 1'b1) begin n_fail++; $display("FAIL zero_tbl_0000: got addr %0d match %b byp %b want 63 1 1", a, m, bo); end
    n_chk++; if (lat != 4) begin n_fail++; $display("FAIL latency_2: got %0d want 4", lat); end
  endtask

  task automatic test_mm_rw();
    logic [47:0] d; logic v; logic [5:0] a; logic m, bo; int lat;
    mm_write(0, 0, {16'h3000, 16'h2000, 16'h1000});
    mm_read(0, 0, d, v);
    n_chk++; if (v !== 1'b1 || d !== {16'h3000, 16'h2000, 16'h1000}) begin n_fail++; $display("FAIL readback_l0: got %h v %b want 300020001000 v 1", d, v); end
    tick();
    n_chk++; if (mm_rdvalid !== 1'b0) begin n_fail++; $display("FAIL rdvalid_pulse: got %b want 0", mm_rdvalid); end
    mm_read(3, 0, d, v);
    n_chk++; if (v !== 1'b1 || d !== 48'h0) begin n_fail++; $display("FAIL read_bad_level: got %h v %b want 0 v 1", d, v); end
    // same-cycle read and write to one address
    mm_addr = {2'd2, 4'd0}; mm_wdata = 48'hAAAA_BBBB_CCCC; mm_wr = 1'b1; mm_rd = 1'b1;
    tick();
    mm_wr = 1'b0; mm_rd = 1'b0;
    n_chk++; if (mm_rdata !== 48'h0) begin n_fail++; $display("FAIL rw_same_old: got %h want 0", mm_rdata); end
    mm_read(2, 0, d, v);
    n_chk++; if (d !== 48'hAAAA_BBBB_CCCC) begin n_fail++; $display("FAIL rw_same_new: got %h want aaaabbbbcccc", d); end
    lookup1(16'h2500, 1'b0, a, m, bo, lat);
    n_chk++; if (a !== 6'd63) begin n_fail++; $display("FAIL shadow_not_live: got %0d want 63", a); end
    swap = 1'b1; tick(); swap = 1'b0;
    n_chk++; if (abank !== 1'b1) begin n_fail++; $display("FAIL swap_bank: got %b want 1", abank); end
    lookup1(16'h2500, 1'b0, a, m, bo, lat);
    n_chk++; if (a !== 6'd47 || m !== 1'b0) begin n_fail++; $display("FAIL live_2500: got %0d match %b want 47 0", a, m); end
    lookup1(16'h3000, 1'b0, a, m, bo, lat);
    n_chk++; if (a !== 6'd63 || m !== 1'b0) begin n_fail++; $display("FAIL live_3000: got %0d match %b want 63 0", a, m); end
  endtask

  task automatic test_swap_busy();
    logic [47:0] d; logic v; int w;
    w = 0;
    while (busy && w < 20) begin tick(); w++; end
    swap = 1'b1; tick(); swap = 1'b0;
    n_chk++; if (abank !== 1'b0) begin n_fail++; $display("FAIL swap_back: got %b want 0", abank); end
    for (int i = 1; i <= 3; i++) begin
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_cycle%0d: got %b want 1", i, busy); end
      mm_addr = {2'd1, 4'(i)}; mm_wdata = 48'h1111 * i; mm_wr = 1'b1;
      tick();
    end
    mm_wr = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_end: got %b want 0", busy); end
    mm_write(1, 0, {16'h0300, 16'h0200, 16'h0100});
    for (int i = 1; i <= 3; i++) begin
      mm_read(1, i, d, v);
      n_chk++; if (d !== 48'h0) begin n_fail++; $display("FAIL busy_wr_ignored%0d: got %h want 0", i, d); end
    end
    mm_read(1, 0, d, v);
    n_chk++; if (d !== {16'h0300, 16'h0200, 16'h0100}) begin n_fail++; $display("FAIL post_busy_wr: got %h want 030002000100", d); end
    mm_write(1, 5, 48'hDEAD);
    mm_read(1, 5, d, v);
    n_chk++; if (v !== 1'b1 || d !== 48'h0) begin n_fail++; $display("FAIL bad_node: got %h v %b want 0 v 1", d, v); end
  endtask

  task automatic test_backpressure();
    logic [15:0] kt [4] = '{16'h0000, 16'h0005, 16'h0000, 16'h0007};
    logic        bt [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        mt [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int acc, got;
    lr_i = 1'b0; acc = 0; lv_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      key = kt[acc % 4]; byp_i = bt[acc % 4];
      if (lr_o) acc++;
      tick();
    end
    lv_i = 1'b0;
    n_chk++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", acc); end
    n_chk++; if (lr_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", lr_o); end
    lr_i = 1'b1; got = 0;
    for (int c = 0; c < 20; c++) begin
      if (lv_o) begin
        if (got < 4) begin
          n_chk++;
          if (laddr !== 6'd63 || lmatch !== mt[got] || byp_o !== bt[got]) begin
            n_fail++;
            $display("FAIL bp_result%0d: got addr %0d match %b byp %b want 63 %b %b", got, laddr, lmatch, byp_o, mt[got], bt[got]);
          end
        end
        got++;
      end
      tick();
    end
    n_chk++; if (got != 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", got); end
    n_chk++; if (lr_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", lr_o); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] kt [4] = '{16'h2500, 16'h2500, 16'h2500, 16'h0500};
    logic [5:0]  at [4] = '{6'd63, 6'd63, 6'd47, 6'd15};
    int got;
    lr_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      key = kt[i]; byp_i = i[0]; lv_i = 1'b1; swap = (i == 1);
      n_chk++; if (lr_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", i, lr_o); end
      tick();
    end
    lv_i = 1'b0; swap = 1'b0; got = 0;
    for (int c = 0; c < 20; c++) begin
      if (lv_o) begin
        if (got < 4) begin
          n_chk++;
          if (laddr !== at[got] || byp_o !== got[0]) begin
            n_fail++;
            $display("FAIL b2b_result%0d: got addr %0d byp %b want %0d %b", got, laddr, byp_o, at[got], got[0]);
          end
        end
        got++;
      end
      tick();
    end
    n_chk++; if (got != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", got); end
    n_chk++; if (abank !== 1'b1) begin n_fail++; $display("FAIL b2b_bank: got %b want 1", abank); end
  endtask

  task automatic test_reset_midflight();
    logic [47:0] d; logic v; int seen;
    lr_i = 1'b0; key = 16'h0042; lv_i = 1'b1;
    repeat (2) tick();
    lv_i = 1'b0;
    repeat (4) tick();
    lv_i = 1'b1;
    repeat (2) tick();
    lv_i = 1'b0;
    n_chk++; if (lv_o !== 1'b1) begin n_fail++; $display("FAIL mid_queued: got %b want 1", lv_o); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (lv_o !== 1'b0) begin n_fail++; $display("FAIL mid_valid_drop: got %b want 0", lv_o); end
    n_chk++; if (abank !== 1'b0) begin n_fail++; $display("FAIL mid_bank: got %b want 0", abank); end
    repeat (2) tick();
    rst_n = 1'b1; lr_i = 1'b1; seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (lv_o) seen++;
      tick();
    end
    n_chk++; if (seen != 0) begin n_fail++; $display("FAIL mid_no_output: got %0d want 0", seen); end
    n_chk++; if (lr_o !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", lr_o); end
    for (int l = 0; l < 3; l++) begin
      mm_read(l, 0, d, v);
      n_chk++; if (d !== 48'h0 || v !== 1'b1) begin n_fail++; $display("FAIL mid_pivot_l%0d: got %h v %b want 0 v 1", l, d, v); end
    end
  endtask

  initial begin
    test_reset();
    test_default_lookup();
    test_mm_rw();
    test_swap_busy();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
